// File: rtl/mul_final_add_stage_if.sv
// Handshake and data bundle between the multiplier tree output, the final-add stage and the EXU.
// The master side drives rows, control and result-ready; the slave side is the final-add stage.
interface mul_final_add_stage_if #(
    parameter int WDITH = 132,
    parameter int XLEN  = 64,
    parameter int TAGW  = 5
);
    logic             i_flush;
    logic             i_valid;
    logic             o_ready;
    logic [WDITH-1:0] i_row0;
    logic [WDITH-1:0] i_row1;
    logic             i_sel_high;
    logic             i_is_word;
    logic [TAGW-1:0]  i_tag;
    logic             o_valid;
    logic             i_ready;
    logic [XLEN-1:0]  o_result;
    logic [TAGW-1:0]  o_tag;

    modport master (
        output i_flush, i_valid, i_row0, i_row1, i_sel_high, i_is_word, i_tag, i_ready,
        input  o_ready, o_valid, o_result, o_tag
    );

    modport slave (
        input  i_flush, i_valid, i_row0, i_row1, i_sel_high, i_is_word, i_tag, i_ready,
        output o_ready, o_valid, o_result, o_tag
    );
endinterface

// File: rtl/mul_final_add_stage.sv
// Final carry-propagate add of the Wallace tree's two rows, split into a low-half and a
// high-half stage, followed by MUL/MULH/MULW result formatting behind an elastic handshake.
module mul_final_add_stage #(
    parameter int WDITH = 132,
    parameter int XLEN  = 64,
    parameter int TAGW  = 5
) (
    input logic                 i_clk,
    input logic                 i_rst,
    mul_final_add_stage_if.slave bus
);
    localparam int HALF = XLEN / 2;

    // stage A state
    logic            va;
    logic [XLEN-1:0] a_lo;
    logic            a_c;
    logic [XLEN-1:0] a_hi0;
    logic [XLEN-1:0] a_hi1;
    logic            a_sel_high;
    logic            a_is_word;
    logic [TAGW-1:0] a_tag;

    // stage B state
    logic            vb;
    logic [XLEN-1:0] result_q;
    logic [TAGW-1:0] tag_q;

    logic            adv_a;
    logic            adv_b;
    logic [XLEN:0]   lo_sum;
    logic [XLEN-1:0] hi_sum;
    logic [XLEN-1:0] res_next;

    // Rows are modulo 2^WDITH, so the bits above the 128-bit product carry no information.
    logic unused_row_top;
    assign unused_row_top = ^{bus.i_row0[WDITH-1:2*XLEN], bus.i_row1[WDITH-1:2*XLEN]};

    assign adv_b = !vb || bus.i_ready;
    assign adv_a = !va || adv_b;

    assign lo_sum = {1'b0, bus.i_row0[XLEN-1:0]} + {1'b0, bus.i_row1[XLEN-1:0]};
    assign hi_sum = a_hi0 + a_hi1 + {{(XLEN-1){1'b0}}, a_c};

    always_comb begin
        res_next = a_lo;
        if (a_sel_high)
            res_next = hi_sum;
        else if (a_is_word)
            res_next = {{HALF{a_lo[HALF-1]}}, a_lo[HALF-1:0]};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            va         <= 1'b0;
            vb         <= 1'b0;
            a_lo       <= '0;
            a_c        <= 1'b0;
            a_hi0      <= '0;
            a_hi1      <= '0;
            a_sel_high <= 1'b0;
            a_is_word  <= 1'b0;
            a_tag      <= '0;
            result_q   <= '0;
            tag_q      <= '0;
        end else begin
            if (bus.i_flush) begin
                va <= 1'b0;
                vb <= 1'b0;
            end else begin
                if (adv_a) va <= bus.i_valid;
                if (adv_b) vb <= va;
            end
            // Data only moves with a valid token so idle cycles keep the last result visible.
            if (adv_a && bus.i_valid) begin
                a_lo       <= lo_sum[XLEN-1:0];
                a_c        <= lo_sum[XLEN];
                a_hi0      <= bus.i_row0[2*XLEN-1:XLEN];
                a_hi1      <= bus.i_row1[2*XLEN-1:XLEN];
                a_sel_high <= bus.i_sel_high;
                a_is_word  <= bus.i_is_word;
                a_tag      <= bus.i_tag;
            end
            if (adv_b && va) begin
                result_q <= res_next;
                tag_q    <= a_tag;
            end
        end
    end

    assign bus.o_ready  = adv_a;
    assign bus.o_valid  = vb;
    assign bus.o_result = result_q;
    assign bus.o_tag    = tag_q;
endmodule

// File: tb/tb_mul_final_add_stage.sv
// Directed bench for mul_final_add_stage: vector table for the arithmetic and formatting,
// plus scripted back-pressure, flush and reset sequences.
module tb_mul_final_add_stage;
    typedef struct {
        logic [131:0] r0;
        logic [131:0] r1;
        logic         sh;
        logic         w;
        logic [4:0]   tag;
        logic [63:0]  exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    mul_final_add_stage_if bus ();

    mul_final_add_stage dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic vld);
        bus.i_valid    = vld;
        bus.i_row0     = v.r0;
        bus.i_row1     = v.r1;
        bus.i_sel_high = v.sh;
        bus.i_is_word  = v.w;
        bus.i_tag      = v.tag;
    endtask

    // One op with i_ready held high: accepted at the first edge, visible after the second.
    task automatic run_vec(input vec_t v, input string name);
        @(negedge clk);
        drive(v, 1'b1);
        chk({name, "_ready"}, 64'(bus.o_ready), 64'd1);
        @(negedge clk);
        bus.i_valid = 1'b0;
        chk({name, "_lat1"}, 64'(bus.o_valid), 64'd0);
        @(negedge clk);
        chk({name, "_valid"}, 64'(bus.o_valid), 64'd1);
        chk({name, "_result"}, bus.o_result, v.exp);
        chk({name, "_tag"}, 64'(bus.o_tag), 64'(v.tag));
    endtask

    // Output monitor for the back-pressure sequence.
    logic        mon_en = 1'b0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_res;
    logic [4:0]  prev_tag;
    logic [63:0] got_res[$];
    logic [4:0]  got_tag[$];
    logic        saw_ready_low = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            #2;
            if (prev_stall) begin
                chk("bp_hold_valid", 64'(bus.o_valid), 64'd1);
                chk("bp_hold_result", bus.o_result, prev_res);
                chk("bp_hold_tag", 64'(bus.o_tag), 64'(prev_tag));
            end
            prev_stall = bus.o_valid && !bus.i_ready;
            prev_res   = bus.o_result;
            prev_tag   = bus.o_tag;
            if (bus.o_valid && bus.i_ready) begin
                got_res.push_back(bus.o_result);
                got_tag.push_back(bus.o_tag);
            end
        end
    end

    vec_t vecs[10];
    vec_t tmp;

    initial begin
        vecs[0] = '{132'd15, 132'd0, 1'b0, 1'b0, 5'd3, 64'd15};
        vecs[1] = '{132'hFFFF_FFFF_FFFF_FFFF, 132'd1, 1'b1, 1'b0, 5'd4, 64'd1};
        vecs[2] = '{132'hFFFF_FFFF_FFFF_FFFF, 132'd1, 1'b0, 1'b0, 5'd5, 64'd0};
        vecs[3] = '{132'h8000_0000, 132'd0, 1'b0, 1'b1, 5'd6, 64'hFFFF_FFFF_8000_0000};
        vecs[4] = '{132'h1_7FFF_FFFF, 132'd0, 1'b0, 1'b1, 5'd7, 64'h0000_0000_7FFF_FFFF};
        vecs[5] = '{132'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 132'd0, 1'b1, 1'b0, 5'd8,
                    64'hFFFF_FFFF_FFFF_FFFE};
        vecs[6] = '{132'hA_FFFF_FFFF_FFFF_FFFD_8000_0000_0000_0000,
                    132'h5_0000_0000_0000_0000_8000_0000_0000_0001, 1'b1, 1'b0, 5'd9,
                    64'hFFFF_FFFF_FFFF_FFFE};
        vecs[7] = '{132'hA_FFFF_FFFF_FFFF_FFFD_8000_0000_0000_0000,
                    132'h5_0000_0000_0000_0000_8000_0000_0000_0001, 1'b0, 1'b0, 5'd10, 64'd1};
        vecs[8] = '{132'h1234_5678_9ABC_DEF0_0000_0000_8000_0000, 132'd0, 1'b1, 1'b1, 5'd11,
                    64'h1234_5678_9ABC_DEF0};
        vecs[9] = '{132'h0123_4567_89AB_CDEF, 132'h1111_1111_1111_1111, 1'b0, 1'b0, 5'd31,
                    64'h1234_5678_9ABC_DF00};

        bus.i_flush = 1'b0;
        bus.i_ready = 1'b1;
        drive(vecs[0], 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_ready", 64'(bus.o_ready), 64'd1);
        chk("rst_result", bus.o_result, 64'd0);
        chk("rst_tag", 64'(bus.o_tag), 64'd0);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Back-pressure: four back-to-back ops, result side stalled for 3 cycles.
        @(negedge clk);
        mon_en = 1'b1;
        fork
            begin
                for (int k = 1; k <= 4; k++) begin
                    int spin;
                    @(negedge clk);
                    tmp = '{132'(k * 100), 132'(k), 1'b0, 1'b0, 5'(k), 64'(k * 101)};
                    drive(tmp, 1'b1);
                    #1;
                    spin = 0;
                    while (!bus.o_ready && spin < 20) begin
                        saw_ready_low = 1'b1;
                        @(negedge clk);
                        #1;
                        spin++;
                    end
                end
                @(negedge clk);
                bus.i_valid = 1'b0;
            end
            begin
                int t;
                t = 0;
                @(negedge clk);
                while (!bus.o_valid && t < 20) begin
                    @(negedge clk);
                    t++;
                end
                chk("bp_first_valid", 64'(bus.o_valid), 64'd1);
                bus.i_ready = 1'b0;
                repeat (3) @(negedge clk);
                bus.i_ready = 1'b1;
            end
        join
        for (int t = 0; t < 30 && got_tag.size() < 4; t++) @(negedge clk);
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        chk("bp_ready_dropped", 64'(saw_ready_low), 64'd1);
        chk("bp_count", 64'(got_tag.size()), 64'd4);
        for (int k = 0; k < 4 && k < got_tag.size(); k++) begin
            chk($sformatf("bp_tag%0d", k + 1), 64'(got_tag[k]), 64'(k + 1));
            chk($sformatf("bp_res%0d", k + 1), got_res[k], 64'((k + 1) * 101));
        end

        // Flush with two ops held in the pipe.
        @(negedge clk);
        bus.i_ready = 1'b0;
        tmp = '{132'd5, 132'd0, 1'b0, 1'b0, 5'd20, 64'd5};
        drive(tmp, 1'b1);
        @(negedge clk);
        tmp.tag = 5'd21;
        drive(tmp, 1'b1);
        @(negedge clk);
        chk("fl_inflight", 64'(bus.o_valid), 64'd1);
        bus.i_flush = 1'b1;
        tmp.tag = 5'd22;
        drive(tmp, 1'b1);
        @(negedge clk);
        bus.i_flush = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("fl_novalid%0d", c), 64'(bus.o_valid), 64'd0);
            @(negedge clk);
        end
        run_vec(vecs[9], "after_flush");

        // Reset with two ops held in the pipe.
        @(negedge clk);
        bus.i_ready = 1'b0;
        tmp.tag = 5'd23;
        drive(tmp, 1'b1);
        @(negedge clk);
        tmp.tag = 5'd24;
        drive(tmp, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        bus.i_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus.i_ready = 1'b1;
        chk("mrst_valid", 64'(bus.o_valid), 64'd0);
        chk("mrst_result", bus.o_result, 64'd0);
        chk("mrst_tag", 64'(bus.o_tag), 64'd0);
        chk("mrst_ready", 64'(bus.o_ready), 64'd1);
        @(negedge clk);
        chk("mrst_novalid", 64'(bus.o_valid), 64'd0);
        run_vec(vecs[0], "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mul_final_add_stage.md
Name: mul_final_add_stage

Overview:
- Downstream consumer of the 33-input Wallace compression tree in the EXU multiplier.
- Takes the tree's two redundant rows (sum row, pre-shifted carry row) and adds them with a 2-stage pipelined carry-propagate adder, low half first, then high half.
- Selects and formats the 64-bit result for MUL/MULH/MULHSU/MULHU/MULW and returns it to the EXU with a valid/ready handshake.

Parameters:
- WDITH, 132, width of each compressed row from the tree; only bits [127:0] are consumed.
- XLEN, 64, result width; also the low/high adder split point.
- TAGW, 5, width of the opaque tag (destination register id) carried alongside each operation.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_flush  in  1  discard all in-flight operations.
- i_valid  in  1  upstream row pair valid.
- o_ready  out  1  stage can accept this cycle.
- i_row0  in  WDITH  sum row (tree out[0]).
- i_row1  in  WDITH  carry row, already shifted (tree out[1]).
- i_sel_high  in  1  1 = return product[127:64] (MULH/MULHSU/MULHU); 0 = low part.
- i_is_word  in  1  1 = MULW, return sign-extended product[31:0]; ignored when i_sel_high=1.
- i_tag  in  TAGW  tag passed through unchanged.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_result  out  XLEN  formatted result.
- o_tag  out  TAGW  tag of the result.

Behaviour:
- Pipeline stage A (registered from inputs):
  - Captures low sum = row0[63:0] + row1[63:0] (64-bit).
  - Captures carry-out cA.
  - Captures row0[127:64], row1[127:64], sel_high, is_word and tag.
- Pipeline stage B (registered from A):
  - Computes high = rowA0_hi + rowA1_hi + cA, modulo 2^64.
  - Result select:
    - sel_high=1: high.
    - sel_high=0, is_word=1: {32{low[31]}, low[31:0]}.
    - otherwise: low.
  - Registers o_result and o_tag; o_valid is B's valid bit.
- Bits [131:128] of both rows are ignored. Tree arithmetic is modulo 2^WDITH, so the 128-bit product is exact in [127:0].
- Latency: 2 cycles, from an accepted i_valid&&o_ready to o_valid, when there are no stalls. Throughput is 1 per cycle.
- Flow control, per stage (elastic, bubble-collapsing):
  - advB = !vB || i_ready.
  - advA = !vA || advB.
  - o_ready = advA (combinational).
  - On advB, B loads A's contents; vB <= vA.
  - On advA, A loads the inputs; vA <= i_valid.
- While o_valid=1 and i_ready=0: o_result and o_tag are held stable and vB stays 1.
- A bubble in B does not block A (advB=1 whenever vB=0).
- Flush: i_flush=1 clears vA and vB at the next edge. Any input presented that cycle is dropped. o_ready may be 1 during the flush cycle, but nothing is captured. Data registers need not clear.
- Reset: i_rst=1 at a clock edge clears vA and vB.
  - o_valid=0 and o_ready=1 from the first cycle after reset.
  - o_result and o_tag reset to 0.
  - Reset mid-operation drops all in-flight operations.
- Reset and flush both win over simultaneous handshakes.
- Data registers update only on their stage-advance enable. No x-propagation onto o_result when o_valid=0; it holds the last value, or 0 after reset.

Test Plan:
- Basic MUL: row0=15, row1=0, sel_high=0, is_word=0, tag=3 -> exactly 2 cycles later o_valid=1, o_result=15, o_tag=3.
- Low-to-high carry: row0=0xFFFF_FFFF_FFFF_FFFF, row1=1, sel_high=1 -> o_result=1. The same rows with sel_high=0 -> o_result=0.
- MULW sign extension: row0=0x0000_0000_8000_0000, row1=0, is_word=1 -> o_result=0xFFFF_FFFF_8000_0000. With row0=0x1_7FFF_FFFF -> o_result=0x7FFF_FFFF.
- MULHU max: rows summing to 0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001 (row0 = that value, row1=0), sel_high=1 -> o_result=0xFFFF_FFFF_FFFF_FFFE. Repeat with the value split across both rows, plus junk in bits [131:128] -> same result.
- Back-pressure: 4 back-to-back ops with tags 1..4; hold i_ready=0 for 3 cycles after the first result appears -> o_ready drops once A and B are full, o_result/o_tag stay stable, and all 4 results emerge in order with no loss or duplication.
- Flush/reset: 2 ops in flight, assert i_flush for 1 cycle -> no o_valid afterwards, and the next op completes normally in 2 cycles. Repeat using i_rst -> o_valid=0, o_result=0, o_ready=1 on the cycle after reset.
